instr_fetch: RTL and testbench

//  Instruction fetch stage feeding the decode/execute path (CONTROLLER, ALU_CONTROLLER, GPREGS, ALU).

---
 rtl/rv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/instr_fetch.sv | 138 +++++++++++++
 tb/tb_instr_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the fetch front end: datapath width, the canonical
// NOP used when nothing is buffered, and the fetch FSM state encoding.
package rv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Flush has priority over push and pop. The head entry is read straight from
// storage, so a word pushed on one edge is visible on the next cycle.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign pop_ok    = pop && !empty;
  // A push into a full buffer is only safe if the head leaves on the same edge.
  assign push_ok   = push && (!full || pop_ok);
  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory, buffers returned words and hands {instruction, pc} to
// decode. A redirect flushes the buffer; a request already on the bus is
// allowed to complete at its original address and its data is thrown away.
module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          XLEN       = 32
) (
  input  logic            clk,
  input  logic            nreset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [XLEN-1:0]   pc_reg;
  logic [XLEN-1:0]   pc_next;
  logic [XLEN-1:0]   drop_addr_reg;
  logic [XLEN-1:0]   drop_addr_next;
  logic [XLEN-1:0]   redirect_target;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [2*XLEN-1:0] fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CW-1:0]     count_after_push;

  assign redirect_target = redirect_pc & ~XLEN'(3);

  // A redirect flushes the buffer, so a pop in that cycle has nothing to remove.
  assign fifo_flush = redirect;
  assign fifo_pop   = inst_valid && inst_ready && !redirect;

  // Occupancy seen by the FSM if the current ack is pushed this cycle.
  assign count_after_push = fifo_count + CW'(1) - CW'(fifo_pop);

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nreset    (nreset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({pc_reg, imem_rdata}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign inst_valid  = !fifo_empty;
  assign instruction = fifo_empty ? XLEN'(NOP_INSTR) : fifo_head[XLEN-1:0];
  assign inst_pc     = fifo_empty ? '0 : fifo_head[2*XLEN-1:XLEN];

  // State, PC and held drop address registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg     <= IDLE;
      pc_reg        <= XLEN'(RESET_PC);
      drop_addr_reg <= XLEN'(RESET_PC);
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_addr_reg <= drop_addr_next;
    end
  end

  // Next-state, PC update and memory interface outputs.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_addr_next = drop_addr_reg;
    fifo_push      = 1'b0;
    imem_req       = 1'b0;
    imem_addr      = pc_reg;

    case (state_reg)
      IDLE: begin
        if (redirect) begin
          pc_next = redirect_target;
        end else if (!fifo_full) begin
          // Nothing is outstanding here, so a free slot is enough to issue.
          state_next = REQ;
        end
      end

      REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_next = redirect_target;
          if (imem_ack) begin
            // The word arriving now belongs to the old stream; drop it.
            state_next = IDLE;
          end else begin
            // The open request must keep its address until it completes.
            drop_addr_next = pc_reg;
            state_next     = DROP;
          end
        end else if (imem_ack) begin
          fifo_push = 1'b1;
          pc_next   = pc_reg + XLEN'(4);
          state_next = (count_after_push < CW'(FIFO_DEPTH)) ? REQ : IDLE;
        end
      end

      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_reg;
        if (redirect) pc_next = redirect_target;
        if (imem_ack) state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a simple memory responder with adjustable
// ack delay, plus recorded deliveries to decode and accepted bus reads.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        nreset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  int n_checks = 0;
  int n_fail   = 0;

  int ack_delay = 1;
  int wait_cnt  = 0;

  logic [31:0] del_pc[$];
  logic [31:0] del_ins[$];
  logic [31:0] acc_addr[$];

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .XLEN       (32)
  ) dut (
    .clk         (clk),
    .nreset      (nreset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .instruction (instruction),
    .inst_pc     (inst_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: log handshakes that complete on the coming edge, then
  // update the memory responder just after the edge.
  task automatic tick();
    if (nreset && inst_valid && inst_ready && !redirect) begin
      del_pc.push_back(inst_pc);
      del_ins.push_back(instruction);
    end
    if (nreset && imem_req && imem_ack) acc_addr.push_back(imem_addr);
    @(posedge clk);
    #1;
    if (!nreset || !imem_req) begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      wait_cnt   = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      wait_cnt++;
    end
  endtask

  task automatic do_reset(input int dly, input logic rdy);
    nreset      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    inst_ready  = rdy;
    ack_delay   = dly;
    wait_cnt    = 0;
    repeat (2) tick();
    nreset = 1'b1;
    del_pc.delete();
    del_ins.delete();
    acc_addr.delete();
  endtask

  task automatic check_del(input string tag, input int idx, input logic [31:0] exp_pc);
    check({tag, "_have"}, 64'(del_pc.size() > idx), 64'd1);
    if (del_pc.size() > idx) begin
      check({tag, "_pc"}, 64'(del_pc[idx]), 64'(exp_pc));
      check({tag, "_ins"}, 64'(del_ins[idx]), 64'(mem_word(exp_pc)));
    end
  endtask

  initial begin
    nreset      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    inst_ready  = 1'b0;

    // 1: reset values, then sustained fetch with one-cycle ack latency
    tick();
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'h0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_instr", 64'(instruction), 64'h13);
    check("rst_pc", 64'(inst_pc), 64'h0);
    do_reset(1, 1'b1);
    check("t1_req_rel", 64'(imem_req), 64'd0);
    tick();
    check("t1_req_first", 64'(imem_req), 64'd1);
    check("t1_addr_first", 64'(imem_addr), 64'h0);
    repeat (20) tick();
    check("t1_ndel", 64'(del_pc.size()), 64'd9);
    check("t1_nacc", 64'(acc_addr.size()), 64'd10);
    for (int i = 0; i < del_pc.size(); i++) begin
      check($sformatf("t1_pc%0d", i), 64'(del_pc[i]), 64'(32'(4 * i)));
      check($sformatf("t1_ins%0d", i), 64'(del_ins[i]), 64'(mem_word(32'(4 * i))));
    end

    // 2: decode stalled, immediate acks -> buffer fills with 0,4 then stops
    do_reset(0, 1'b0);
    repeat (7) tick();
    check("t2_req_stop", 64'(imem_req), 64'd0);
    check("t2_nacc", 64'(acc_addr.size()), 64'd2);
    check("t2_valid", 64'(inst_valid), 64'd1);
    check("t2_head_pc", 64'(inst_pc), 64'h0);
    check("t2_head_ins", 64'(instruction), 64'(mem_word(32'h0)));
    inst_ready = 1'b1;
    repeat (12) tick();
    check_del("t2_d0", 0, 32'h0);
    check_del("t2_d1", 1, 32'h4);
    check_del("t2_d2", 2, 32'h8);
    check("t2_acc2_have", 64'(acc_addr.size() > 2), 64'd1);
    if (acc_addr.size() > 2) check("t2_acc2", 64'(acc_addr[2]), 64'h8);

    // 3: redirect while a slow request is open -> address held, word dropped
    do_reset(4, 1'b1);
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    check("t3_drop_req", 64'(imem_req), 64'd1);
    check("t3_drop_addr0", 64'(imem_addr), 64'h0);
    check("t3_drop_valid", 64'(inst_valid), 64'd0);
    tick();
    check("t3_drop_addr1", 64'(imem_addr), 64'h0);
    tick();
    check("t3_drop_ack_addr", 64'(imem_addr), 64'h0);
    tick();
    check("t3_idle_req", 64'(imem_req), 64'd0);
    tick();
    check("t3_new_req", 64'(imem_req), 64'd1);
    check("t3_new_addr", 64'(imem_addr), 64'h100);
    repeat (20) tick();
    check_del("t3_d0", 0, 32'h100);

    // 4: redirect coincident with ack -> that word never reaches decode
    do_reset(1, 1'b1);
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    check("t4_valid", 64'(inst_valid), 64'd0);
    check("t4_instr", 64'(instruction), 64'h13);
    check("t4_req_idle", 64'(imem_req), 64'd0);
    repeat (12) tick();
    check_del("t4_d0", 0, 32'h40);
    check_del("t4_d1", 1, 32'h44);

    // 5: redirect to the top word -> PC wraps to zero; low bits ignored
    do_reset(1, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    check("t5_idle_req", 64'(imem_req), 64'd0);
    tick();
    check("t5_req", 64'(imem_req), 64'd1);
    check("t5_addr", 64'(imem_addr), 64'hFFFF_FFFC);
    repeat (12) tick();
    check_del("t5_d0", 0, 32'hFFFF_FFFC);
    check_del("t5_d1", 1, 32'h0);
    check_del("t5_d2", 2, 32'h4);

    // 6: reset asserted with an entry buffered and a request open
    do_reset(2, 1'b0);
    repeat (4) tick();
    check("t6_pre_valid", 64'(inst_valid), 64'd1);
    check("t6_pre_req", 64'(imem_req), 64'd1);
    check("t6_pre_addr", 64'(imem_addr), 64'h4);
    nreset   = 1'b0;
    imem_ack = 1'b0;
    tick();
    check("t6_req", 64'(imem_req), 64'd0);
    check("t6_valid", 64'(inst_valid), 64'd0);
    check("t6_instr", 64'(instruction), 64'h13);
    check("t6_pc", 64'(inst_pc), 64'h0);
    nreset = 1'b1;
    tick();
    check("t6_rel_req", 64'(imem_req), 64'd1);
    check("t6_rel_addr", 64'(imem_addr), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
